audio_sample_scheduler: RTL

//  Sits between the I2S receiver output (stereo sample pair plus update strobe, already

---
 rtl/audio_pkg.sv | 19 +
 rtl/sample_fifo.sv | 50 +++++
 rtl/audio_sample_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared encodings and defaults for the audio sample scheduler.
package audio_pkg;

  localparam int CH_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_MONO  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_MUTE  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO of stereo pairs. The read data is a combinational look at
// the head slot, so a push and a pop in the same cycle on a full FIFO return
// the old head before its slot is overwritten.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Buffers stereo pairs from the I2S receiver, prefills, then hands one mixed
// sample to the FM modulator per out_ready tick. Mutes on underrun/link loss.
module audio_sample_scheduler
  import audio_pkg::*;
#(
  parameter int CH_WIDTH       = audio_pkg::CH_WIDTH,
  parameter int FIFO_DEPTH     = 8,
  parameter int PREFILL        = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_strobe,
  input  logic [CH_WIDTH-1:0]  in_first,
  input  logic [CH_WIDTH-1:0]  in_second,
  input  logic [1:0]           mode,
  input  logic                 out_ready,
  output logic [CH_WIDTH-1:0]  out_sample,
  output logic                 out_valid,
  output logic                 active,
  output logic [CNT_WIDTH-1:0] underrun_count,
  output logic                 overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t              state, nxt;
  logic                strobe_q;
  logic                push, push_ok, pop, underrun, timeout;
  logic                full, empty;
  logic [CW-1:0]       count, occ_next;
  logic [2*CH_WIDTH-1:0] head;
  logic [TW-1:0]       tcnt;
  logic [CH_WIDTH-1:0] left, right, mixed;
  logic [CH_WIDTH:0]   sum;

  // A strobe held high for several cycles must count as a single push.
  assign push     = in_strobe & ~strobe_q;
  assign pop      = (state == ST_RUN) & out_ready & ~empty;
  assign underrun = (state == ST_RUN) & out_ready & empty;
  assign push_ok  = push & (~full | pop);
  assign occ_next = count + CW'(push_ok) - CW'(pop);
  // A push in the same cycle keeps the link alive, so it beats the timeout.
  assign timeout  = (state != ST_IDLE) & ~push & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign active   = (state == ST_RUN);

  sample_fifo #(
    .WIDTH (2*CH_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (timeout),
    .wdata ({in_first, in_second}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Channel mixer on the FIFO head; the wide sum halves with floor rounding
  // and can never overflow the output width.
  always_comb begin
    left  = head[2*CH_WIDTH-1:CH_WIDTH];
    right = head[CH_WIDTH-1:0];
    sum   = {left[CH_WIDTH-1], left} + {right[CH_WIDTH-1], right};
    mixed = '0;
    case (mode_t'(mode))
      MODE_MONO:  mixed = sum[CH_WIDTH:1];
      MODE_LEFT:  mixed = left;
      MODE_RIGHT: mixed = right;
      default:    mixed = '0;
    endcase
  end

  // State register and strobe history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      strobe_q <= 1'b0;
    end else begin
      state    <= nxt;
      strobe_q <= in_strobe;
    end
  end

  // Next-state: prefill gate, underrun fallback, link-loss override.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (push) nxt = ST_FILL;
      ST_FILL: if (occ_next >= CW'(PREFILL)) nxt = ST_RUN;
      ST_RUN:  if (underrun) nxt = ST_FILL;
      default: nxt = ST_IDLE;
    endcase
    if (timeout) nxt = ST_IDLE;
  end

  // Link-loss counter: idle-held, cleared by pushes and by its own expiry.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE || push || timeout) tcnt <= '0;
    else                                           tcnt <= tcnt + 1'b1;
  end

  // Output register: every tick answers next cycle, with silence if nothing popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sample <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= out_ready;
      if (out_ready) out_sample <= pop ? mixed : '0;
    end
  end

  // Status: saturating underrun count and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count <= '0;
      overflow       <= 1'b0;
    end else begin
      if (underrun && underrun_count != '1) underrun_count <= underrun_count + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
